// File: rtl/a2d_rr_sched.sv
// Round-robin scheduler for the shared SPI A2D master. Each round converts
// left load cell, right load cell, steering pot and battery in that order.
// Each channel takes two frames: a command frame that starts the conversion,
// then a read frame (same command word) that returns the result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for nxt
// CMD       | snd pulse for the command frame of the current channel
// WAIT_CMD  | waiting for done of the command frame (resp discarded)
// GAP       | A2D conversion time between command and read frames
// READ      | snd pulse for the read frame, cmd unchanged
// WAIT_READ | waiting for done of the read frame, capture result
// FIN       | round_done pulse; nxt is still ignored here
module a2d_rr_sched #(
  parameter logic [2:0] LFT_CH   = 3'd0,
  parameter logic [2:0] RGHT_CH  = 3'd4,
  parameter logic [2:0] STEER_CH = 3'd5,
  parameter logic [2:0] BATT_CH  = 3'd6,
  parameter int         GAP_CYC  = 8,
  parameter int         TMO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        round_done,
  output logic        err
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WAIT_CMD, GAP, READ, WAIT_READ, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [11:0]   lft_q, lft_d;
  logic [11:0]   rght_q, rght_d;
  logic [11:0]   steer_q, steer_d;
  logic [11:0]   batt_q, batt_d;
  logic          tmo_hit;

  // Upper resp bits carry no conversion data.
  logic unused_resp_hi;
  assign unused_resp_hi = ^resp[15:12];

  function automatic logic [15:0] cmd_of(input logic [1:0] i);
    logic [2:0] ch;
    case (i)
      2'd0: ch = LFT_CH;
      2'd1: ch = RGHT_CH;
      2'd2: ch = STEER_CH;
      2'd3: ch = BATT_CH;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  // done arriving on the last timeout cycle wins over the abort.
  assign tmo_hit = (tmo_q == TMO_LAST) && !done;

  // State and datapath registers, all cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      cmd_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      steer_q <= '0;
      batt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    cmd_d   = cmd_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d = CMD;
          idx_d   = 2'd0;
          cmd_d   = cmd_of(2'd0);
        end
      end
      CMD: begin
        tmo_d   = '0;
        state_d = WAIT_CMD;
      end
      WAIT_CMD: begin
        if (done) begin
          gap_d   = '0;
          state_d = GAP;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = READ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      READ: begin
        tmo_d   = '0;
        state_d = WAIT_READ;
      end
      WAIT_READ: begin
        if (done) begin
          case (idx_q)
            2'd0: lft_d   = resp[11:0];
            2'd1: rght_d  = resp[11:0];
            2'd2: steer_d = resp[11:0];
            2'd3: batt_d  = resp[11:0];
          endcase
          if (idx_q == 2'd3) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            cmd_d   = cmd_of(idx_q + 1'b1);
            state_d = CMD;
          end
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs from state; err also qualifies on the timeout compare.
  always_comb begin
    snd        = (state_q == CMD) || (state_q == READ);
    busy       = (state_q != IDLE) && (state_q != FIN);
    round_done = (state_q == FIN);
    err        = ((state_q == WAIT_CMD) || (state_q == WAIT_READ)) && tmo_hit;
  end

  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Scoreboard bench for a2d_rr_sched: stimulus pushes expected commands and
// round outcomes into queues, a responder plays the SPI master, and a monitor
// compares whenever the scheduler emits snd, round_done or err.
module tb_a2d_rr_sched;

  localparam int GAP_CYC = 8;
  localparam int TMO_CYC = 1024;
  localparam logic [2:0] CH_ADDR [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, round_done, err;

  a2d_rr_sched #(
    .LFT_CH(3'd0), .RGHT_CH(3'd4), .STEER_CH(3'd5), .BATT_CH(3'd6),
    .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .snd(snd), .cmd(cmd),
    .done(done), .resp(resp), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .busy(busy),
    .round_done(round_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hold;
    logic [15:0] dly;
    logic [15:0] rsp;
  } plan_t;

  typedef struct packed {
    logic        is_err;
    logic [47:0] res;
  } evt_t;

  logic [15:0] exp_cmd[$];
  plan_t       plan[$];
  evt_t        exp_evt[$];
  logic [11:0] exp_res[4];
  logic [15:0] rv[4];

  int n_vec = 0;
  int n_err = 0;
  int spur_req = 0;
  int spur_srv = 0;
  int snd_total = 0;
  longint cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cmd_for(input int i);
    return {2'b00, CH_ADDR[i], 11'h000};
  endfunction

  function automatic logic [47:0] res_snap();
    return {exp_res[3], exp_res[2], exp_res[1], exp_res[0]};
  endfunction

  // Responder: answers each snd per the plan, or sends a requested spurious done.
  initial begin
    plan_t p;
    done = 1'b0;
    resp = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && snd) begin
        if (plan.size() != 0) begin
          p = plan.pop_front();
          if (!p.hold) begin
            repeat (int'(p.dly)) @(posedge clk);
            #1 done = 1'b1; resp = p.rsp;
            @(posedge clk);
            #1 done = 1'b0; resp = 16'($urandom);
          end
        end
      end else if (spur_req != spur_srv) begin
        spur_srv++;
        @(posedge clk);
        #1 done = 1'b1; resp = 16'h0FFF;
        @(posedge clk);
        #1 done = 1'b0;
      end
    end
  end

  // Monitor: command words, frame spacing, round outcome and timeout latency.
  initial begin
    int     frames = 0;
    longint last_done = 0;
    longint last_snd = 0;
    evt_t   e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        frames = 0;
      end else begin
        if (snd) begin
          frames++;
          snd_total++;
          if (exp_cmd.size() == 0) chk("unexpected_snd", 1, 0);
          else chk("cmd", cmd, exp_cmd.pop_front());
          if (frames % 2 == 0) chk("gap_spacing", 64'(cyc - last_done), GAP_CYC + 1);
          last_snd = cyc;
        end
        if (done && busy) last_done = cyc;
        if (round_done || err) begin
          if (exp_evt.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = exp_evt.pop_front();
            chk("event_is_err", err, e.is_err);
            chk("results", {batt, steer_pot, rght_ld, lft_ld}, e.res);
            if (round_done) chk("frames_per_round", frames, 8);
            if (err) chk("tmo_latency", 64'(cyc - last_snd), TMO_CYC);
          end
          frames = 0;
        end
      end
    end
  end

  // One round: hold_f withholds done on that frame (-1 none); coinc_f answers
  // that frame exactly on the timeout cycle.
  task automatic run_round(input int hold_f, input int coinc_f);
    plan_t p;
    evt_t  e;
    bit    fin = 0;
    for (int f = 0; f < 8; f++) begin
      if (hold_f < 0 || f <= hold_f) begin
        exp_cmd.push_back(cmd_for(f / 2));
        p.hold = (f == hold_f);
        p.dly  = (f == coinc_f) ? 16'(TMO_CYC) : 16'($urandom_range(1, 6));
        p.rsp  = (f % 2 == 1) ? rv[f / 2] : 16'($urandom);
        plan.push_back(p);
      end
    end
    for (int i = 0; i < 4; i++)
      if (hold_f < 0 || 2 * i + 1 < hold_f) exp_res[i] = rv[i][11:0];
    e.is_err = (hold_f >= 0);
    e.res    = res_snap();
    exp_evt.push_back(e);

    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    chk("snd_latency", snd, 1);
    chk("busy_at_start", busy, 1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (round_done) nxt = 1'b1;
      else if (!busy) begin nxt = 1'b0; fin = 1; break; end
      else nxt = ($urandom_range(0, 7) == 0);
    end
    nxt = 1'b0;
    chk("round_finished", fin, 1);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("evt_queue_drained", exp_evt.size(), 0);
  endtask

  initial begin
    int   base;
    bit   seen;
    plan_t p;
    rst_n = 1'b0;
    nxt   = 1'b0;
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {snd, busy, round_done, err, cmd}, 0);
    chk("rst_results", {batt, steer_pot, rght_ld, lft_ld}, 0);
    rst_n = 1'b1;

    // Directed round with known readings.
    rv[0] = 16'h0ABC; rv[1] = 16'h0123; rv[2] = 16'h0800; rv[3] = 16'h0FFF;
    run_round(-1, -1);

    // Upper nibble of resp dropped.
    rv[0] = 16'hF555; rv[1] = 16'h1AAA; rv[2] = 16'h8001; rv[3] = 16'hE7E7;
    run_round(-1, -1);

    // Spurious done while idle.
    spur_req++;
    repeat (5) @(posedge clk);
    #1;
    chk("spur_busy", busy, 0);
    chk("spur_results", {batt, steer_pot, rght_ld, lft_ld}, res_snap());

    // Timeout on the RGHT_CH command frame, then a clean round.
    for (int i = 0; i < 4; i++) rv[i] = 16'($urandom);
    run_round(2, -1);
    chk("busy_after_err", busy, 0);
    for (int i = 0; i < 4; i++) rv[i] = 16'($urandom);
    run_round(-1, -1);

    // done coincident with the timeout cycle on a read frame.
    for (int i = 0; i < 4; i++) rv[i] = 16'($urandom);
    run_round(-1, 3);

    // Randomized rounds, some with a withheld frame.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) rv[i] = 16'($urandom);
      run_round(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
    end

    // Reset during the GAP of the STEER_CH command frame.
    for (int f = 0; f < 5; f++) begin
      exp_cmd.push_back(cmd_for(f / 2));
      p.hold = 1'b0; p.dly = 16'd1; p.rsp = 16'($urandom);
      plan.push_back(p);
    end
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (snd && cmd == 16'h2800) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("steer_cmd_seen", seen, 1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {snd, busy, round_done, err, cmd}, 0);
    chk("midrst_results", {batt, steer_pot, rght_ld, lft_ld}, 0);
    exp_cmd.delete();
    plan.delete();
    exp_evt.delete();
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    @(posedge clk); #1 rst_n = 1'b1;
    base = snd_total;
    repeat (20) @(posedge clk);
    #1;
    chk("no_snd_after_rst", snd_total - base, 0);
    chk("idle_after_rst", busy, 0);

    for (int i = 0; i < 4; i++) rv[i] = 16'($urandom);
    run_round(-1, -1);

    repeat (5) @(posedge clk);
    chk("plan_drained", plan.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
